stage_ctrl: RTL
===============

STAGE_CTRL -- requirements
Module: stage_ctrl

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15, maximum cycles spent waiting for mem_rdy_i in FETCH or MEMORY before an address fault.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 icode_i  input  `BYTE  instruction code of the current instruction, valid from DECODE onward.
REQ-005 ifun_i  input  `BYTE  function code of the current instruction.
REQ-006 valA_i, valB_i, valE_i  input  `WORD each  execute-unit operands and result, valid in EXECUTE.
REQ-007 mem_rdy_i  input  1  instruction or data memory access complete.
REQ-008 mem_err_i  input  1  memory access faulted; sampled with mem_rdy_i.
REQ-009 fetch_en_o, decode_en_o, exe_en_o, mem_en_o, wb_en_o, pc_en_o  output  1 each  one-hot stage enables.
REQ-010 cc_o  output  3  condition codes {ZF,SF,OF}.
REQ-011 cnd_o  output  1  registered condition result for CMOVXX/JXX.
REQ-012 stat_o  output  `BYTE  status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-013 halt_o  output  1  processor stopped.

Function
REQ-014 FSM states SHALL be FETCH, DECODE, EXECUTE, MEMORY, WBACK, PCUPD, HALT; each enable is high only in its state (Moore, decoded from state register).
REQ-015 FETCH SHALL hold until mem_rdy_i=1, then go to DECODE; mem_err_i=1 with mem_rdy_i SHALL go to HALT with stat ADR.
REQ-016 DECODE SHALL go to HALT with stat HLT if icode_i=0, HALT with stat INS if icode_i>0xB, else EXECUTE; each one cycle.
REQ-017 EXECUTE SHALL go to MEMORY for icodes 4,5,8,9,A,B; else to WBACK for icodes 2,3,6; else (NOP, JXX) to PCUPD.
REQ-018 MEMORY SHALL hold until mem_rdy_i, then go to WBACK, except RMMOVL (4) which goes to PCUPD; mem_err_i → HALT/ADR.
REQ-019 Wait counter SHALL clear on entering FETCH or MEMORY, increment per waiting cycle, and force HALT/ADR when it reaches MEM_WAIT_MAX without mem_rdy_i; mem_rdy_i on the same cycle as the limit wins.
REQ-020 WBACK and PCUPD SHALL each last one cycle; PCUPD SHALL return to FETCH.
REQ-021 cc_o SHALL update only on leaving EXECUTE with icode_i=6: ZF=(valE_i==0), SF=valE_i[31], OF per ifun: ADDL sign(A)==sign(B) and sign(E)!=sign(A); SUBL sign(A)!=sign(B) and sign(E)!=sign(B); ANDL/XORL 0.
REQ-022 cnd_o SHALL latch in EXECUTE for icodes 2 and 7 from the pre-update cc_o: ifun 0 always, 1 LE, 2 L, 3 E, 4 NE, 5 GE, 6 G; ifun>6 yields 0.
REQ-023 HALT SHALL be absorbing: all enables 0, halt_o=1, stat_o and cc_o frozen until rst.

Reset
REQ-024 rst SHALL force state FETCH, cc_o=3'b100, cnd_o=0, stat_o=AOK, halt_o=0, wait counter 0 on the next edge, overriding any state including HALT and mid-wait MEMORY.
REQ-025 In the first cycle after reset fetch_en_o SHALL be 1.

Configuration
REQ-026 Macro STAGE_CTRL_INSTR_CNT_EN defined: output instr_cnt_o [`WORD] increments on each PCUPD cycle, resets to 0, wraps 0xFFFFFFFF→0; undefined: port and counter absent.

Structure
REQ-027 defines.v SHALL hold icode/ifun constants, state encodings, CC bit positions, and stat codes.
REQ-028 Condition evaluation SHALL be a combinational sub-module cond_eval (cc, ifun → cnd).

Verification
REQ-029 irmovl then addl 0x7FFFFFFF+1 (valE=0x80000000) → cc_o={0,1,1}, state path FETCH-DECODE-EXECUTE-WBACK-PCUPD, 5 cycles with immediate mem_rdy_i.
REQ-030 subl valA=5, valB=5 then jle (ifun 1) → cc_o={1,0,0}, cnd_o=1, no MEMORY/WBACK visited.
REQ-031 mrmovl with mem_rdy_i delayed 3 cycles → mem_en_o high 4 cycles, then WBACK.
REQ-032 mem_rdy_i never asserted in MEMORY → HALT after 15 wait cycles, stat_o=3, halt_o=1.
REQ-033 icode 0xC in DECODE → HALT, stat_o=4; rst pulse → fetch_en_o=1, stat_o=1, cc_o=3'b100.
REQ-034 With STAGE_CTRL_INSTR_CNT_EN, three NOPs → instr_cnt_o=3.

Source files
------------

// File: rtl/stage_ctrl_pkg.sv
// Shared constants for the Y86 stage controller: widths, instruction/function codes,
// FSM states, condition-code bit positions and status codes.
package stage_ctrl_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WBACK,
        ST_PCUPD,
        ST_HALT
    } state_t;

    localparam logic [BYTE_W-1:0] I_HALT   = 8'h0;
    localparam logic [BYTE_W-1:0] I_NOP    = 8'h1;
    localparam logic [BYTE_W-1:0] I_RRMOVL = 8'h2;
    localparam logic [BYTE_W-1:0] I_IRMOVL = 8'h3;
    localparam logic [BYTE_W-1:0] I_RMMOVL = 8'h4;
    localparam logic [BYTE_W-1:0] I_MRMOVL = 8'h5;
    localparam logic [BYTE_W-1:0] I_OPL    = 8'h6;
    localparam logic [BYTE_W-1:0] I_JXX    = 8'h7;
    localparam logic [BYTE_W-1:0] I_CALL   = 8'h8;
    localparam logic [BYTE_W-1:0] I_RET    = 8'h9;
    localparam logic [BYTE_W-1:0] I_PUSHL  = 8'hA;
    localparam logic [BYTE_W-1:0] I_POPL   = 8'hB;

    localparam logic [BYTE_W-1:0] ALU_ADD = 8'h0;
    localparam logic [BYTE_W-1:0] ALU_SUB = 8'h1;
    localparam logic [BYTE_W-1:0] ALU_AND = 8'h2;
    localparam logic [BYTE_W-1:0] ALU_XOR = 8'h3;

    localparam logic [BYTE_W-1:0] C_ALWAYS = 8'h0;
    localparam logic [BYTE_W-1:0] C_LE     = 8'h1;
    localparam logic [BYTE_W-1:0] C_L      = 8'h2;
    localparam logic [BYTE_W-1:0] C_E      = 8'h3;
    localparam logic [BYTE_W-1:0] C_NE     = 8'h4;
    localparam logic [BYTE_W-1:0] C_GE     = 8'h5;
    localparam logic [BYTE_W-1:0] C_G      = 8'h6;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;
    localparam logic [2:0] CC_RESET = 3'b100;

    localparam logic [BYTE_W-1:0] STAT_AOK = 8'd1;
    localparam logic [BYTE_W-1:0] STAT_HLT = 8'd2;
    localparam logic [BYTE_W-1:0] STAT_ADR = 8'd3;
    localparam logic [BYTE_W-1:0] STAT_INS = 8'd4;

    // Flags produced by an OPL result; overflow is judged from operand/result signs.
    function automatic logic [2:0] opl_cc(input logic [BYTE_W-1:0] ifun,
                                          input logic [WORD_W-1:0] a,
                                          input logic [WORD_W-1:0] b,
                                          input logic [WORD_W-1:0] e);
        logic [2:0] cc;
        cc        = '0;
        cc[CC_ZF] = (e == '0);
        cc[CC_SF] = e[WORD_W-1];
        case (ifun)
            ALU_ADD: cc[CC_OF] = (a[WORD_W-1] == b[WORD_W-1]) && (e[WORD_W-1] != a[WORD_W-1]);
            ALU_SUB: cc[CC_OF] = (a[WORD_W-1] != b[WORD_W-1]) && (e[WORD_W-1] != b[WORD_W-1]);
            default: cc[CC_OF] = 1'b0;
        endcase
        return cc;
    endfunction

endpackage

// File: rtl/stage_ctrl_if.sv
// Datapath <-> stage controller signal bundle; master is the controller side.
interface stage_ctrl_if;
    import stage_ctrl_pkg::*;

    logic [BYTE_W-1:0] icode_i;
    logic [BYTE_W-1:0] ifun_i;
    logic [WORD_W-1:0] valA_i;
    logic [WORD_W-1:0] valB_i;
    logic [WORD_W-1:0] valE_i;
    logic              mem_rdy_i;
    logic              mem_err_i;
    logic              fetch_en_o;
    logic              decode_en_o;
    logic              exe_en_o;
    logic              mem_en_o;
    logic              wb_en_o;
    logic              pc_en_o;
    logic [2:0]        cc_o;
    logic              cnd_o;
    logic [BYTE_W-1:0] stat_o;
    logic              halt_o;

    modport master (
        input  icode_i, ifun_i, valA_i, valB_i, valE_i, mem_rdy_i, mem_err_i,
        output fetch_en_o, decode_en_o, exe_en_o, mem_en_o, wb_en_o, pc_en_o,
               cc_o, cnd_o, stat_o, halt_o
    );

    modport slave (
        output icode_i, ifun_i, valA_i, valB_i, valE_i, mem_rdy_i, mem_err_i,
        input  fetch_en_o, decode_en_o, exe_en_o, mem_en_o, wb_en_o, pc_en_o,
               cc_o, cnd_o, stat_o, halt_o
    );

endinterface

// File: rtl/stage_ctrl_cond_eval.sv
// Combinational branch/move condition from condition codes {ZF,SF,OF} and ifun.
module cond_eval
    import stage_ctrl_pkg::*;
(
    input  logic [2:0]        i_cc,
    input  logic [BYTE_W-1:0] i_ifun,
    output logic              o_cnd
);

    logic w_zf;
    logic w_lt;

    assign w_zf = i_cc[CC_ZF];
    assign w_lt = i_cc[CC_SF] ^ i_cc[CC_OF];

    always_comb begin
        o_cnd = 1'b0;
        case (i_ifun)
            C_ALWAYS: o_cnd = 1'b1;
            C_LE:     o_cnd = w_lt | w_zf;
            C_L:      o_cnd = w_lt;
            C_E:      o_cnd = w_zf;
            C_NE:     o_cnd = ~w_zf;
            C_GE:     o_cnd = ~w_lt;
            C_G:      o_cnd = ~w_lt & ~w_zf;
            default:  o_cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/stage_ctrl.sv
// Multi-cycle Y86 stage sequencer with memory-wait timeout, condition codes and status.
// Optional STAGE_CTRL_INSTR_CNT_EN adds instr_cnt_o, counting completed PC updates.
module stage_ctrl
    import stage_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    stage_ctrl_if.master      bus
`ifdef STAGE_CTRL_INSTR_CNT_EN
    ,
    output logic [WORD_W-1:0] instr_cnt_o
`endif
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [2:0]        r_cc;
    logic              r_cnd;
    logic [BYTE_W-1:0] r_stat;

    state_t            w_state_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [2:0]        w_cc_nxt;
    logic              w_cnd_nxt;
    logic [BYTE_W-1:0] w_stat_nxt;
    logic              w_cond;
    logic              w_timeout;

    cond_eval u_cond_eval (
        .i_cc   (r_cc),
        .i_ifun (bus.ifun_i),
        .o_cnd  (w_cond)
    );

    assign w_timeout = (r_wait == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_wait  <= '0;
            r_cc    <= CC_RESET;
            r_cnd   <= 1'b0;
            r_stat  <= STAT_AOK;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_cc    <= w_cc_nxt;
            r_cnd   <= w_cnd_nxt;
            r_stat  <= w_stat_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_nxt      = r_wait;
        w_cc_nxt        = r_cc;
        w_cnd_nxt       = r_cnd;
        w_stat_nxt      = r_stat;
        bus.fetch_en_o  = 1'b0;
        bus.decode_en_o = 1'b0;
        bus.exe_en_o    = 1'b0;
        bus.mem_en_o    = 1'b0;
        bus.wb_en_o     = 1'b0;
        bus.pc_en_o     = 1'b0;
        bus.halt_o      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                bus.fetch_en_o = 1'b1;
                // A ready on the last permitted wait cycle takes priority over the timeout.
                if (bus.mem_rdy_i) begin
                    if (bus.mem_err_i) begin
                        w_state_nxt = ST_HALT;
                        w_stat_nxt  = STAT_ADR;
                    end else begin
                        w_state_nxt = ST_DECODE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_HALT;
                    w_stat_nxt  = STAT_ADR;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            ST_DECODE: begin
                bus.decode_en_o = 1'b1;
                if (bus.icode_i == I_HALT) begin
                    w_state_nxt = ST_HALT;
                    w_stat_nxt  = STAT_HLT;
                end else if (bus.icode_i > I_POPL) begin
                    w_state_nxt = ST_HALT;
                    w_stat_nxt  = STAT_INS;
                end else begin
                    w_state_nxt = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                bus.exe_en_o = 1'b1;
                if (bus.icode_i == I_OPL)
                    w_cc_nxt = opl_cc(bus.ifun_i, bus.valA_i, bus.valB_i, bus.valE_i);
                if (bus.icode_i == I_RRMOVL || bus.icode_i == I_JXX)
                    w_cnd_nxt = w_cond;
                case (bus.icode_i)
                    I_RMMOVL, I_MRMOVL, I_CALL, I_RET, I_PUSHL, I_POPL: begin
                        w_state_nxt = ST_MEMORY;
                        w_wait_nxt  = '0;
                    end
                    I_RRMOVL, I_IRMOVL, I_OPL: w_state_nxt = ST_WBACK;
                    default:                   w_state_nxt = ST_PCUPD;
                endcase
            end
            ST_MEMORY: begin
                bus.mem_en_o = 1'b1;
                if (bus.mem_rdy_i) begin
                    if (bus.mem_err_i) begin
                        w_state_nxt = ST_HALT;
                        w_stat_nxt  = STAT_ADR;
                    end else if (bus.icode_i == I_RMMOVL) begin
                        w_state_nxt = ST_PCUPD;
                    end else begin
                        w_state_nxt = ST_WBACK;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_HALT;
                    w_stat_nxt  = STAT_ADR;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            ST_WBACK: begin
                bus.wb_en_o = 1'b1;
                w_state_nxt = ST_PCUPD;
            end
            ST_PCUPD: begin
                bus.pc_en_o = 1'b1;
                w_state_nxt = ST_FETCH;
                w_wait_nxt  = '0;
            end
            ST_HALT: begin
                bus.halt_o = 1'b1;
            end
            default: begin
                w_state_nxt = ST_HALT;
                w_stat_nxt  = STAT_INS;
            end
        endcase
    end

    assign bus.cc_o   = r_cc;
    assign bus.cnd_o  = r_cnd;
    assign bus.stat_o = r_stat;

`ifdef STAGE_CTRL_INSTR_CNT_EN
    logic [WORD_W-1:0] r_instr_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_instr_cnt <= '0;
        else if (r_state == ST_PCUPD)
            r_instr_cnt <= r_instr_cnt + 1'b1;
    end

    assign instr_cnt_o = r_instr_cnt;
`endif

endmodule
